// File: rtl/dds_parallel_pkg.sv
// dds_parallel_pkg: shared DDS stream constants, serializer state encoding and lane-index width helper
package dds_parallel_pkg;
  localparam int DDS_CHANNEL = 8;
  localparam int DATA_WIDTH = 16;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dds_beat_fifo.sv
// dds_beat_fifo: 2-entry beat buffer exposing the head entry and the entry behind it
module dds_beat_fifo #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [W-1:0] second,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic rd, wr;
  assign head = mem[rd];
  assign second = mem[~rd];
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= 1'b0;
      wr <= 1'b0;
      count <= 2'd0;
    end else begin
      wr <= wr ^ push;
      rd <= rd ^ pop;
      count <= count + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/dds_parallel_serializer.sv
// dds_parallel_serializer: AXIS parallel-beat to one-sample-per-clock serializer with sticky underflow.
// Define OFFSET_BINARY_EN to invert each output sample MSB (two's complement to offset binary).
module dds_parallel_serializer
  import dds_parallel_pkg::*;
#(
  parameter int dds_channel = DDS_CHANNEL,
  parameter int data_width = DATA_WIDTH,
  localparam int CW = lane_w(dds_channel)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [data_width*dds_channel-1:0] s_axis_tdata,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  output logic [data_width-1:0]             m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [CW-1:0]                     m_axis_tuser,
  output logic                              m_axis_tlast,
  output logic                              underflow,
  input  logic                              underflow_clr
);
  localparam int BW = data_width * dds_channel;
  localparam logic [CW-1:0] LAST = CW'(dds_channel - 1);
  logic init_done, started, push, hs, pop, load;
  logic [0:0] state;
  logic [1:0] count;
  logic [BW-1:0] head, second, src;
  logic [CW-1:0] lane_nxt;
  logic [data_width-1:0] sample;
  dds_beat_fifo #(.W(BW)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .din(s_axis_tdata), .head(head), .second(second), .count(count)
  );
  assign s_axis_tready = init_done && count != 2'd2;
  assign push = s_axis_tvalid && s_axis_tready;
  assign hs = m_axis_tvalid && m_axis_tready;
  assign pop = hs && m_axis_tlast;
  // On the last-lane pop the next beat is either the buffered one or the beat arriving this very cycle
  always_comb begin
    src = (pop && count == 2'd1) ? s_axis_tdata : pop ? second : head;
    load = hs ? (!m_axis_tlast || count == 2'd2 || push) : (!m_axis_tvalid && count != 2'd0);
    lane_nxt = (hs && !m_axis_tlast) ? m_axis_tuser + CW'(1) : '0;
    sample = src[int'(lane_nxt)*data_width +: data_width];
`ifdef OFFSET_BINARY_EN
    sample[data_width-1] = ~sample[data_width-1];
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      init_done <= 1'b0;
      started <= 1'b0;
      state <= IDLE;
      underflow <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tuser <= '0;
      m_axis_tlast <= 1'b0;
    end else begin
      init_done <= 1'b1;
      started <= started | hs;
      state <= (state == IDLE && push) ? RUN : (pop && count == 2'd1 && !push) ? IDLE : state;
      underflow <= (started && state == IDLE && m_axis_tready) || (underflow && !underflow_clr);
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata <= sample;
        m_axis_tuser <= lane_nxt;
        m_axis_tlast <= lane_nxt == LAST;
      end else if (hs) m_axis_tvalid <= 1'b0;
    end
endmodule

// File: tb/tb_dds_parallel_serializer.sv
// tb_dds_parallel_serializer: random and directed stimulus with a queue scoreboard of expected samples
module tb_dds_parallel_serializer;
  localparam int C = 8;
  localparam int W = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [C*W-1:0] s_data = '0;
  logic s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b1, m_last, underflow, clr = 1'b0;
  logic [W-1:0] m_data;
  logic [2:0] m_user;
  typedef struct packed { logic [W-1:0] d; logic [2:0] lane; } exp_t;
  exp_t exp_q[$];
  int tests = 0, fails = 0;
  bit prev_stall = 0;
  logic [W+3:0] prev_out;
  bit rand_done = 0;

  dds_parallel_serializer #(.dds_channel(C), .data_width(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_axis_tuser(m_user), .m_axis_tlast(m_last),
    .underflow(underflow), .underflow_clr(clr)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ob(input logic [W-1:0] d);
`ifdef OFFSET_BINARY_EN
    return d ^ 16'h8000;
`else
    return d;
`endif
  endfunction

  function automatic logic [C*W-1:0] rand_beat();
    logic [C*W-1:0] b;
    for (int k = 0; k < C; k++) b[k*W +: W] = W'($urandom);
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: accepted beats expand to lanes 0..C-1 in order; every output handshake pops one
  always @(negedge clk) begin
    if (!rst_n) prev_stall <= 0;
    else begin
      if (s_valid && s_ready)
        for (int k = 0; k < C; k++) exp_q.push_back('{s_data[k*W +: W], 3'(k)});
      if (prev_stall) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_bundle", 32'({m_data, m_user, m_last}), 32'(prev_out));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_sample: got %0h with nothing expected", m_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("tdata", 32'(m_data), 32'(ob(e.d)));
          check("tuser", 32'(m_user), 32'(e.lane));
          check("tlast", 32'(m_last), 32'(e.lane == 3'(C - 1)));
        end
      end
      prev_stall <= m_valid && !m_ready;
      prev_out <= {m_data, m_user, m_last};
    end
  end

  task automatic send(input logic [C*W-1:0] b);
    int t = 0;
    s_data = b;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: s_axis_tready got 0 expected 1");
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_lane(input int lane);
    int t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!(m_valid && m_user == 3'(lane)) && t < 100);
    check("wait_lane", 32'(m_user), 32'(lane));
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [C*W-1:0] b;
    int t, bubbles, uf;
    bit saw_low;
    // Reset
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", 32'({m_data, m_user, m_valid, m_last, underflow}), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("s_ready_first", 32'(s_ready), 32'd0);
    @(negedge clk);
    check("s_ready_after", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    // Continuous beats: no bubble, underflow quiet while streaming
    bubbles = 0; uf = 0; saw_low = 0;
    fork
      for (int i = 0; i < 4; i++) send(rand_beat());
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!m_valid && t < 100);
        for (int i = 0; i < 32; i++) begin
          if (!m_valid) bubbles++;
          if (!s_ready) saw_low = 1;
          if (underflow) uf++;
          if (i < 31) @(negedge clk);
        end
      end
    join
    check("stream_bubbles", 32'(bubbles), 32'd0);
    check("stream_ready_drop", 32'(saw_low), 32'd1);
    check("stream_underflow", 32'(uf), 32'd0);
    repeat (3) @(posedge clk);
    #1 m_ready = 1'b0;
    pulse_clr();
    @(negedge clk);
    check("clr_idle", 32'(underflow), 32'd0);
    // Single beat: latency 1, lanes in order, then underflow
    for (int k = 0; k < C; k++) b[k*W +: W] = W'(k);
    @(posedge clk);
    #1;
    send(b);
    m_ready = 1'b1;
    @(negedge clk);
    check("lat_valid0", 32'(m_valid), 32'd0);
    for (int k = 0; k < C; k++) begin
      @(negedge clk);
      check("single_data", 32'(m_data), 32'(ob(W'(k))));
      check("single_last", 32'(m_last), 32'(k == C - 1));
      check("single_uf", 32'(underflow), 32'd0);
    end
    @(negedge clk);
    check("single_end_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("single_underflow", 32'(underflow), 32'd1);
    // Clear loses to a simultaneous set; clear alone works
    @(posedge clk);
    #1;
    pulse_clr();
    @(negedge clk);
    check("clr_vs_set", 32'(underflow), 32'd1);
    @(posedge clk);
    #1 m_ready = 1'b0;
    pulse_clr();
    @(negedge clk);
    check("clr_alone", 32'(underflow), 32'd0);
    @(posedge clk);
    #1 m_ready = 1'b1;
    // Backpressure on lane 3 with two beats held
    send(rand_beat());
    send(rand_beat());
    wait_lane(3);
    m_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_lane", 32'(m_user), 32'd3);
      check("bp_s_ready", 32'(s_ready), 32'd0);
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(m_valid && m_last) && t < 50);
    check("bp_ready_at_pop", 32'(s_ready), 32'd0);
    @(negedge clk);
    check("bp_ready_after_pop", 32'(s_ready), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    // Reset mid-beat discards the old beat
    send(rand_beat());
    wait_lane(4);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_valid", 32'(m_valid), 32'd0);
    check("midrst_ready", 32'(s_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    b = rand_beat();
    send(b);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!m_valid && t < 20);
    check("midrst_lane", 32'(m_user), 32'd0);
    check("midrst_data", 32'(m_data), 32'(ob(b[W-1:0])));
    repeat (10) @(posedge clk);
    #1;
`ifdef OFFSET_BINARY_EN
    b = rand_beat();
    b[W-1:0] = 16'h8000;
    b[2*W-1:W] = 16'h7FFF;
    b[3*W-1:2*W] = 16'h0000;
    send(b);
    @(negedge clk);
    @(negedge clk);
    check("ob_8000", 32'(m_data), 32'h0000);
    @(negedge clk);
    check("ob_7fff", 32'(m_data), 32'hFFFF);
    @(negedge clk);
    check("ob_0000", 32'(m_data), 32'h8000);
    repeat (8) @(posedge clk);
    #1;
`endif
    // Random beats, gaps and backpressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2) * (($urandom_range(0, 3) == 0) ? 4 : 1)) begin
            @(posedge clk);
            #1;
          end
          send(rand_beat());
        end
        rand_done = 1;
      end
      while (!rand_done) begin
        @(posedge clk);
        #1 m_ready = $urandom_range(0, 3) != 0;
      end
    join
    m_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dds_parallel_serializer.md
Name: dds_parallel_serializer

Overview:
- Consumer end of the parallel DDS sample stream: an AXI-Stream slave that accepts one beat of dds_channel packed samples per handshake.
- Emits the samples one per clock, in time order, on an AXI-Stream master for a single-lane DAC/JESD or a test capture path.
- Double-buffered so that full throughput is sustained when input beats arrive every dds_channel cycles.
- Flags stream underflow, i.e. gaps that would corrupt a continuous waveform.

Parameters:
- dds_channel, 8, samples packed per input beat; must be >=1.
- data_width, 16, bits per sample.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- s_axis_tdata  in  data_width*dds_channel  packed beat; lane k in bits [data_width*(k+1)-1 : data_width*k]
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  block can accept a beat
- m_axis_tdata  out  data_width  serial sample
- m_axis_tvalid  out  1  sample valid
- m_axis_tready  in  1  downstream accept
- m_axis_tuser  out  CW  lane index of current sample; CW = max(1, clog2(dds_channel))
- m_axis_tlast  out  1  high on lane dds_channel-1
- underflow  out  1  sticky underflow flag
- underflow_clr  in  1  synchronous clear of underflow

Behaviour:
- Reset values:
  - m_axis_tdata, m_axis_tuser, m_axis_tvalid, m_axis_tlast, underflow = 0.
  - Buffer count = 0, lane counter = 0, started = 0.
  - s_axis_tready = 0 during reset.
- s_axis_tready = init_done AND (buffer count != 2).
  - init_done is a flop, reset 0, set 1 on the first clk edge after rst_n release.
- Buffer: 2-entry beat FIFO.
  - Push on s_axis_tvalid & s_axis_tready.
  - Pop when the lane dds_channel-1 sample handshakes.
  - Simultaneous push and pop with count=2 is impossible, because tready is low at count=2.
  - Simultaneous push and pop with count=1 leaves count at 1.
- Output stage is registered.
  - A beat accepted at edge N into an empty block presents lane 0 with m_axis_tvalid=1 after edge N+1; latency is 1 cycle.
- Lane order: lane 0 first (earliest phase), ascending to dds_channel-1.
  - Lane counter advances only on m_axis_tvalid & m_axis_tready.
  - Wraps to 0 after lane dds_channel-1, when the next buffered beat is presented with no bubble.
- AXIS rule: while m_axis_tvalid=1 and m_axis_tready=0, tdata, tuser and tlast are held stable. tvalid never drops without a handshake.
- States:
  - IDLE: buffer empty, tvalid=0. Goes to RUN on push.
  - RUN: serializing. Goes to IDLE after the last-lane handshake with no further beat buffered.
- started is set on the first output handshake and cleared only by reset.
- underflow is set in any cycle where started=1, state=IDLE and m_axis_tready=1.
  - underflow_clr clears it.
  - Set wins over a simultaneous clear.
- dds_channel=1: registered pass-through. m_axis_tuser=0 and m_axis_tlast=1 on every sample.
- Reset mid-beat: all buffered data is discarded. After release, the first output is lane 0 of the next accepted beat.
- No arithmetic on samples, except under the optional feature.

Optional Feature:
- Macro OFFSET_BINARY_EN.
  - Defined: the MSB of each output sample is inverted (two's complement to offset binary for the DAC). Applied in the output register, so there is no extra latency.
  - Undefined: samples pass unchanged.

Decomposition:
- Shared package dds_parallel_pkg:
  - lane-index width function (max(1, clog2(n))).
  - Default DDS_CHANNEL / DATA_WIDTH constants, shared with the parallel DDS generator.
  - State encoding constants IDLE/RUN.
- One sub-module, dds_beat_fifo: a 2-entry beat buffer with push/pop/count and data out of the head entry.
- Serializer FSM, lane counter and underflow logic stay in the top.

Test Plan (dds_channel=8, data_width=16 unless noted):
1. Reset: hold rst_n=0 for 5 cycles -> all outputs 0 and s_axis_tready=0. s_axis_tready=1 one cycle after release.
2. Single beat, lanes 0x0000..0x0007, accepted at edge N, m_axis_tready=1 -> tdata 0x0000..0x0007 on cycles N+1..N+8, tuser 0..7, tlast only with 0x0007. tvalid=0 at N+9, then underflow=1.
3. Continuous beats, 4 beats each offered as soon as tready=1 -> 32 consecutive samples with no bubble, s_axis_tready dropping while 2 beats are held, underflow stays 0.
4. Backpressure: m_axis_tready=0 for 5 cycles while lane 3 is presented -> tdata/tuser held, no loss or duplication. With 2 beats buffered, s_axis_tready=0 until the lane-7 pop.
5. underflow set, then underflow_clr asserted in a set cycle -> underflow remains 1. Clear in a non-underflow cycle -> 0.
6. Reset asserted at lane 4 -> next beat output starts at lane 0 and the old beat never appears. With OFFSET_BINARY_EN defined: input 0x8000 -> 0x0000, 0x7FFF -> 0xFFFF, 0x0000 -> 0x8000.
